// File: rtl/load_store_unit.sv
// Memory-access stage: turns the ALU result into one byte/half/word load or store
// over a req/ack handshake, stalling the core via busy until the transfer completes.

module lsu_store_lane #(
   parameter int LANE = 0
) (
   input  logic       is_store,
   input  logic [1:0] size,
   input  logic [1:0] off,
   input  logic [7:0] b0,
   input  logic [7:0] b1,
   input  logic [7:0] own,
   output logic       be,
   output logic [7:0] data
);
   localparam logic [1:0] LI = LANE[1:0];

   // Loads always fetch the full word; the extractor picks the bytes afterwards.
   always_comb begin
      be   = 1'b1;
      data = 8'h00;
      if (is_store) begin
         case (size)
            2'b00: begin
               be   = (off == LI);
               data = b0;
            end
            2'b01: begin
               be   = (off[1] == LI[1]);
               data = LI[0] ? b1 : b0;
            end
            default: data = own;
         endcase
      end
   end
endmodule

module load_store_unit #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic            is_store,
   input  logic [2:0]      funct3,
   input  logic [XLEN-1:0] addr,
   input  logic [XLEN-1:0] wdata,
   output logic            busy,
   output logic            done,
   output logic            fault,
   output logic [XLEN-1:0] rdata,
   output logic            mem_req,
   output logic            mem_we,
   output logic [XLEN-1:0] mem_addr,
   output logic [3:0]      mem_be,
   output logic [XLEN-1:0] mem_wdata,
   input  logic            mem_ack,
   input  logic [XLEN-1:0] mem_rdata
);
   localparam int NUM_LANES = XLEN / 8;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_REQ  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   typedef struct packed {
      logic                      req;
      logic                      we;
      logic [XLEN-1:0]           addr;
      logic [NUM_LANES-1:0]      be;
      logic [XLEN-1:0]           wdata;
   } mem_req_t;

   logic [1:0]                  state;
   logic [1:0]                  off_q;
   logic [2:0]                  f3_q;
   logic                        st_q;
   logic                        legal;
   mem_req_t                    req_q;
   logic [NUM_LANES-1:0]        lane_be;
   logic [NUM_LANES-1:0][7:0]   lane_data;
   logic [XLEN-1:0]             shifted;
   logic [XLEN-1:0]             ld_ext;

   always_comb begin
      legal = 1'b0;
      case (funct3)
         3'b000:  legal = 1'b1;
         3'b001:  legal = ~addr[0];
         3'b010:  legal = (addr[1:0] == 2'b00);
         3'b100:  legal = ~is_store;
         3'b101:  legal = ~is_store & ~addr[0];
         default: legal = 1'b0;
      endcase
   end

   genvar g;
   generate
      for (g = 0; g < NUM_LANES; g++) begin : g_lane
         lsu_store_lane #(.LANE(g)) u_lane (
            .is_store (is_store),
            .size     (funct3[1:0]),
            .off      (addr[1:0]),
            .b0       (wdata[7:0]),
            .b1       (wdata[15:8]),
            .own      (wdata[8*g +: 8]),
            .be       (lane_be[g]),
            .data     (lane_data[g])
         );
      end
   endgenerate

   // Align the addressed byte/half down to bit 0, then extend per funct3.
   assign shifted = mem_rdata >> {off_q, 3'b000};

   always_comb begin
      case (f3_q)
         3'b000:  ld_ext = {{(XLEN-8){shifted[7]}}, shifted[7:0]};
         3'b001:  ld_ext = {{(XLEN-16){shifted[15]}}, shifted[15:0]};
         3'b100:  ld_ext = {{(XLEN-8){1'b0}}, shifted[7:0]};
         3'b101:  ld_ext = {{(XLEN-16){1'b0}}, shifted[15:0]};
         default: ld_ext = shifted;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_IDLE;
         fault <= 1'b0;
         rdata <= '0;
         req_q <= '0;
         off_q <= 2'b00;
         f3_q  <= 3'b000;
         st_q  <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  if (legal) begin
                     state       <= S_REQ;
                     req_q.req   <= 1'b1;
                     req_q.we    <= is_store;
                     req_q.addr  <= {addr[XLEN-1:2], 2'b00};
                     req_q.be    <= lane_be;
                     req_q.wdata <= lane_data;
                     off_q       <= addr[1:0];
                     f3_q        <= funct3;
                     st_q        <= is_store;
                  end else begin
                     state <= S_DONE;
                     fault <= 1'b1;
                  end
               end
            end
            S_REQ: begin
               if (mem_ack) begin
                  state     <= S_DONE;
                  fault     <= 1'b0;
                  req_q.req <= 1'b0;
                  req_q.we  <= 1'b0;
                  if (!st_q) rdata <= ld_ext;
               end
            end
            S_DONE: begin
               state <= S_IDLE;
               fault <= 1'b0;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assign busy      = ((state == S_IDLE) && start && legal) || (state == S_REQ);
   assign done      = (state == S_DONE);
   assign mem_req   = req_q.req;
   assign mem_we    = req_q.we;
   assign mem_addr  = req_q.addr;
   assign mem_be    = req_q.be;
   assign mem_wdata = req_q.wdata;
endmodule
